// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: requester, ALU and statistics signals of the shared-ALU arbiter
interface alu_share_arbiter_if #(
  parameter int CNT_W = 16
);
  logic req0, req1, ack0, ack1, zero, busy, alu_zero;
  logic [5:0] opcode0, func0, opcode1, func1, alu_opcode, alu_func;
  logic [31:0] a0, b0, a1, b1, result, alu_a, alu_b, alu_result;
  logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;
  modport master (
    output req0, opcode0, func0, a0, b0, req1, opcode1, func1, a1, b1, alu_result, alu_zero,
    input ack0, ack1, result, zero, busy, alu_opcode, alu_func, alu_a, alu_b, gnt_cnt0, gnt_cnt1
  );
  modport slave (
    input req0, opcode0, func0, a0, b0, req1, opcode1, func1, a1, b1, alu_result, alu_zero,
    output ack0, ack1, result, zero, busy, alu_opcode, alu_func, alu_a, alu_b, gnt_cnt0, gnt_cnt1
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two requesters
module alu_share_arbiter #(
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  alu_share_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state;
  logic owner, last_grant, pick1;
  always_comb pick1 = bus.req1 & (~bus.req0 | ~last_grant);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      last_grant <= 1'b1;
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      bus.result <= '0;
      bus.zero <= 1'b0;
      bus.busy <= 1'b0;
      bus.alu_opcode <= '0;
      bus.alu_func <= '0;
      bus.alu_a <= '0;
      bus.alu_b <= '0;
      bus.gnt_cnt0 <= '0;
      bus.gnt_cnt1 <= '0;
    end else begin
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      case (state)
        IDLE: if (bus.req0 | bus.req1) begin
          owner <= pick1;
          bus.alu_opcode <= pick1 ? bus.opcode1 : bus.opcode0;
          bus.alu_func <= pick1 ? bus.func1 : bus.func0;
          bus.alu_a <= pick1 ? bus.a1 : bus.a0;
          bus.alu_b <= pick1 ? bus.b1 : bus.b0;
          bus.busy <= 1'b1;
          state <= EXEC;
        end
        EXEC: begin
          bus.result <= bus.alu_result;
          bus.zero <= bus.alu_zero;
          bus.ack0 <= ~owner;
          bus.ack1 <= owner;
          state <= DONE;
        end
        default: begin
          last_grant <= owner;
          if (!owner && !(&bus.gnt_cnt0)) bus.gnt_cnt0 <= bus.gnt_cnt0 + CNT_W'(1);
          if (owner && !(&bus.gnt_cnt1)) bus.gnt_cnt1 <= bus.gnt_cnt1 + CNT_W'(1);
          bus.busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: vector table, corner sequences and randomized model check of the ALU arbiter
module tb_alu_share_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  alu_share_arbiter_if #(.CNT_W(16)) bus();
  alu_share_arbiter_if #(.CNT_W(2)) sbus();
  alu_share_arbiter #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  alu_share_arbiter #(.CNT_W(2)) sdut (.clk(clk), .rst(rst), .bus(sbus.slave));
  always #5 clk = ~clk;
  function automatic logic [32:0] alu_f(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = a + b;
    if (op == 6'h00) begin
      case (fn)
        6'h22, 6'h23: r = a - b;
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h26: r = a ^ b;
        6'h27: r = ~(a | b);
        6'h2a: r = 32'($signed(a) < $signed(b));
        6'h2b: r = 32'(a < b);
        default: r = a + b;
      endcase
    end else if (op == 6'h0c) r = a & b;
    else if (op == 6'h0d) r = a | b;
    return {r == 32'd0, r};
  endfunction
  always_comb {bus.alu_zero, bus.alu_result} = alu_f(bus.alu_opcode, bus.alu_func, bus.alu_a, bus.alu_b);
  always_comb {sbus.alu_zero, sbus.alu_result} = alu_f(sbus.alu_opcode, sbus.alu_func, sbus.alu_a, sbus.alu_b);
  typedef struct {
    logic r0, r1;
    logic [5:0] op0, fn0;
    logic [31:0] a0, b0;
    logic [5:0] op1, fn1;
    logic [31:0] a1, b1;
    logic who;
    logic [31:0] res;
    logic z;
  } vec_t;
  vec_t vt [7];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  task automatic set0(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    bus.req0 = r;
    bus.opcode0 = op;
    bus.func0 = fn;
    bus.a0 = a;
    bus.b0 = b;
  endtask
  task automatic set1(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    bus.req1 = r;
    bus.opcode1 = op;
    bus.func1 = fn;
    bus.a1 = a;
    bus.b1 = b;
  endtask
  task automatic rnd_op(output logic [5:0] op, output logic [5:0] fn);
    int k;
    k = $urandom_range(0, 12);
    op = 6'h00;
    fn = 6'($urandom);
    case (k)
      0: fn = 6'h20;
      1: fn = 6'h21;
      2: fn = 6'h22;
      3: fn = 6'h23;
      4: fn = 6'h24;
      5: fn = 6'h25;
      6: fn = 6'h26;
      7: fn = 6'h27;
      8: fn = 6'h2a;
      9: fn = 6'h2b;
      10: op = 6'h08;
      11: op = 6'h0c;
      default: op = 6'h0d;
    endcase
  endtask
  initial begin
    int who_q[$];
    int cyc_q[$];
    int lg, c0, c1;
    logic r0, r1, w;
    logic [5:0] op0, fn0, op1, fn1;
    logic [31:0] a0, b0, a1, b1;
    logic [32:0] e;
    vt[0] = '{1, 0, 6'h00, 6'h20, 32'd5, 32'd7, 6'h00, 6'h00, 32'd0, 32'd0, 0, 32'd12, 0};
    vt[1] = '{0, 1, 6'h00, 6'h00, 32'd0, 32'd0, 6'h00, 6'h22, 32'd9, 32'd9, 1, 32'd0, 1};
    vt[2] = '{1, 1, 6'h00, 6'h24, 32'hF0F0, 32'hFF00, 6'h00, 6'h25, 32'd1, 32'd2, 0, 32'hF000, 0};
    vt[3] = '{1, 1, 6'h00, 6'h24, 32'hF0F0, 32'hFF00, 6'h00, 6'h25, 32'd1, 32'd2, 1, 32'd3, 0};
    vt[4] = '{1, 0, 6'h00, 6'h2a, 32'hFFFFFFFF, 32'd1, 6'h00, 6'h00, 32'd0, 32'd0, 0, 32'd1, 0};
    vt[5] = '{0, 1, 6'h00, 6'h00, 32'd0, 32'd0, 6'h00, 6'h27, 32'd0, 32'd0, 1, 32'hFFFFFFFF, 0};
    vt[6] = '{1, 1, 6'h08, 6'h00, 32'd100, 32'hFFFFFF9C, 6'h00, 6'h20, 32'd3, 32'd4, 0, 32'd0, 1};
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    sbus.req0 = 0; sbus.req1 = 0; sbus.opcode0 = 0; sbus.func0 = 0; sbus.a0 = 0; sbus.b0 = 0;
    sbus.opcode1 = 0; sbus.func1 = 0; sbus.a1 = 0; sbus.b1 = 0;
    step();
    step();
    chk("rst_ack", 64'({bus.ack0, bus.ack1}), 0);
    chk("rst_result", 64'(bus.result), 0);
    chk("rst_zero", 64'(bus.zero), 0);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_alu", 64'({bus.alu_opcode, bus.alu_func, bus.alu_a}), 0);
    chk("rst_cnt", 64'({bus.gnt_cnt0, bus.gnt_cnt1}), 0);
    rst = 0;
    for (int i = 0; i < 7; i++) begin
      set0(vt[i].r0, vt[i].op0, vt[i].fn0, vt[i].a0, vt[i].b0);
      set1(vt[i].r1, vt[i].op1, vt[i].fn1, vt[i].a1, vt[i].b1);
      step();
      chk($sformatf("v%0d_busy", i), 64'(bus.busy), 1);
      chk($sformatf("v%0d_early_ack", i), 64'({bus.ack0, bus.ack1}), 0);
      step();
      chk($sformatf("v%0d_ack0", i), 64'(bus.ack0), 64'(!vt[i].who));
      chk($sformatf("v%0d_ack1", i), 64'(bus.ack1), 64'(vt[i].who));
      chk($sformatf("v%0d_result", i), 64'(bus.result), 64'(vt[i].res));
      chk($sformatf("v%0d_zero", i), 64'(bus.zero), 64'(vt[i].z));
      bus.req0 = 0;
      bus.req1 = 0;
      step();
      chk($sformatf("v%0d_idle", i), 64'({bus.ack0, bus.ack1, bus.busy}), 0);
      chk($sformatf("v%0d_hold_a", i), 64'(bus.alu_a), 64'(vt[i].who ? vt[i].a1 : vt[i].a0));
      chk($sformatf("v%0d_hold_res", i), 64'(bus.result), 64'(vt[i].res));
    end
    chk("tbl_cnt0", 64'(bus.gnt_cnt0), 4);
    chk("tbl_cnt1", 64'(bus.gnt_cnt1), 3);
    rst = 1;
    step();
    rst = 0;
    set0(1, 6'h00, 6'h20, 32'd1, 32'd1);
    set1(1, 6'h00, 6'h20, 32'd2, 32'd2);
    for (int c = 1; c <= 40 && who_q.size() < 6; c++) begin
      step();
      chk("fair_not_both", 64'(bus.ack0 & bus.ack1), 0);
      if (bus.ack0 | bus.ack1) begin
        who_q.push_back(int'(bus.ack1));
        cyc_q.push_back(c);
        chk("fair_result", 64'(bus.result), bus.ack1 ? 4 : 2);
        if (who_q.size() == 6) begin
          bus.req0 = 0;
          bus.req1 = 0;
        end
      end
    end
    chk("fair_count", 64'(who_q.size()), 6);
    if (who_q.size() == 6) begin
      chk("fair_first_cyc", 64'(cyc_q[0]), 2);
      for (int i = 0; i < 6; i++) chk($sformatf("fair_order%0d", i), 64'(who_q[i]), 64'(i % 2));
      for (int i = 1; i < 6; i++) chk($sformatf("fair_gap%0d", i), 64'(cyc_q[i] - cyc_q[i-1]), 3);
    end
    step();
    chk("fair_cnt0", 64'(bus.gnt_cnt0), 3);
    chk("fair_cnt1", 64'(bus.gnt_cnt1), 3);
    set0(1, 6'h00, 6'h20, 32'd10, 32'd20);
    set1(0, 0, 0, 0, 0);
    step();
    bus.a0 = 32'd999;
    bus.func0 = 6'h22;
    bus.req0 = 0;
    step();
    chk("inflight_ack0", 64'(bus.ack0), 1);
    chk("inflight_result", 64'(bus.result), 30);
    step();
    set1(1, 6'h00, 6'h22, 32'd50, 32'd8);
    step();
    chk("rst_exec_busy_pre", 64'(bus.busy), 1);
    rst = 1;
    bus.req1 = 0;
    step();
    rst = 0;
    chk("rst_exec_ack", 64'({bus.ack0, bus.ack1}), 0);
    chk("rst_exec_result", 64'(bus.result), 0);
    chk("rst_exec_zero", 64'(bus.zero), 0);
    chk("rst_exec_busy", 64'(bus.busy), 0);
    chk("rst_exec_cnt", 64'({bus.gnt_cnt0, bus.gnt_cnt1}), 0);
    set0(1, 6'h00, 6'h20, 32'd1, 32'd2);
    set1(1, 6'h00, 6'h20, 32'd3, 32'd4);
    step();
    step();
    chk("rst_tie_ack0", 64'(bus.ack0), 1);
    chk("rst_tie_result", 64'(bus.result), 3);
    bus.req0 = 0;
    bus.req1 = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    lg = 1;
    c0 = 0;
    c1 = 0;
    for (int n = 0; n < 300; n++) begin
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      rnd_op(op0, fn0);
      rnd_op(op1, fn1);
      a0 = $urandom;
      b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
      a1 = $urandom;
      b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
      set0(r0, op0, fn0, a0, b0);
      set1(r1, op1, fn1, a1, b1);
      if (!r0 && !r1) begin
        step();
        chk("rnd_idle_busy", 64'(bus.busy), 0);
        continue;
      end
      w = (r0 && r1) ? (lg == 0) : r1;
      e = w ? alu_f(op1, fn1, a1, b1) : alu_f(op0, fn0, a0, b0);
      step();
      chk("rnd_busy", 64'(bus.busy), 1);
      bus.a0 = $urandom;
      bus.b1 = $urandom;
      bus.func0 = 6'($urandom);
      bus.opcode1 = 6'($urandom);
      step();
      chk("rnd_ack0", 64'(bus.ack0), 64'(!w));
      chk("rnd_ack1", 64'(bus.ack1), 64'(w));
      chk("rnd_result", 64'(bus.result), 64'(e[31:0]));
      chk("rnd_zero", 64'(bus.zero), 64'(e[32]));
      bus.req0 = 0;
      bus.req1 = 0;
      step();
      lg = int'(w);
      if (w) c1++;
      else c0++;
      chk("rnd_cnt0", 64'(bus.gnt_cnt0), 64'(c0));
      chk("rnd_cnt1", 64'(bus.gnt_cnt1), 64'(c1));
    end
    for (int k = 1; k <= 5; k++) begin
      sbus.req0 = 1;
      sbus.opcode0 = 6'h00;
      sbus.func0 = 6'h20;
      sbus.a0 = 32'(k);
      sbus.b0 = 32'd1;
      step();
      step();
      chk("sat_ack0", 64'(sbus.ack0), 1);
      chk("sat_result", 64'(sbus.result), 64'(k + 1));
      sbus.req0 = 0;
      step();
      chk($sformatf("sat_cnt%0d", k), 64'(sbus.gnt_cnt0), 64'(k > 3 ? 3 : k));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single combinational ALU between two requesters: the fetch/branch-target path (requester 0) and the execute path (requester 1). It uses a round-robin, 3-state sequencer. It latches the winning requester's operation into registers, drives the shared ALU from them, and returns a registered result and zero flag with a one-cycle ack. It sits between the requesters and the ALU's opcode/func_field/A/B inputs and result/zero outputs.

Parameters:
CNT_W, 16, width of per-requester grant counters (statistics, saturating)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
req0  input  1  requester 0 operation request (level, held until ack0)
opcode0  input  6  requester 0 MIPS opcode
func0  input  6  requester 0 function field
a0  input  32  requester 0 operand A
b0  input  32  requester 0 operand B
req1  input  1  requester 1 request
opcode1  input  6  requester 1 opcode
func1  input  6  requester 1 function field
a1  input  32  requester 1 operand A
b1  input  32  requester 1 operand B
ack0  output  1  one-cycle pulse: result/zero valid for requester 0
ack1  output  1  one-cycle pulse: result/zero valid for requester 1
result  output  32  registered ALU result of the last completed operation
zero  output  1  registered ALU zero flag of the last completed operation
busy  output  1  high in EXEC and DONE
alu_opcode  output  6  to shared ALU, from latched op register
alu_func  output  6  to shared ALU
alu_a  output  32  to shared ALU
alu_b  output  32  to shared ALU
alu_result  input  32  from shared ALU (combinational)
alu_zero  input  1  from shared ALU
gnt_cnt0  output  CNT_W  number of completed ops for requester 0
gnt_cnt1  output  CNT_W  number of completed ops for requester 1

Behaviour:
- Reset: clk and rst as named above; rst is synchronous, active-high. On reset: state=IDLE; ack0=ack1=0; result=0; zero=0; busy=0; alu_* registers=0; gnt_cnt0=gnt_cnt1=0; last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Only reqN asserted: owner=N.
  - Both asserted: owner = the requester that is not last_grant.
  - On any grant: latch opcodeN/funcN/aN/bN into the alu_* registers and the owner register, then go to EXEC.
- EXEC: the ALU evaluates from the latched registers. At the clock edge, capture alu_result into result and alu_zero into zero, then go to DONE. Requester inputs are ignored in this state; changes to operands or a dropped req do not affect the operation in flight.
- DONE:
  - Assert ack[owner]=1 for exactly this cycle.
  - At the edge: set last_grant=owner, increment gnt_cnt[owner] (saturating at all-ones, no wrap), go to IDLE.
- Latency: request sampled at edge t (IDLE) -> ack high during cycle t+2. Peak throughput is 1 op per 3 cycles.
- Handshake:
  - A requester holds req and operands stable until it sees ack.
  - It must deassert req in the cycle after ack. A req still high at the next IDLE sample is treated as a new request.
  - result/zero hold their value until the next EXEC capture, so they stay readable after ack.
- Fairness: with both req continuously high, grants alternate 0,1,0,1,...
- alu_* outputs hold the last latched operation in IDLE and DONE; they do not return to zero.
- ack0 and ack1 are never high together. busy = (state != IDLE).
- Reset mid-operation (EXEC or DONE): the operation is abandoned with no ack, counters are cleared, and all reset values apply on the next cycle.
- The arbiter has no arithmetic of its own: result and zero are exactly what the ALU returns for the latched inputs.

Test Plan:
- Reset, then req0 with opcode0=0, func0=0x20 (add), a0=5, b0=7. Required: ack0 two cycles after the sample; result=12, zero=0; gnt_cnt0=1.
- req1 only, func1=0x22 (sub), a1=9, b1=9. Required: ack1 pulse; result=0, zero=1; ack0 stays 0.
- req0 and req1 raised together from reset. Required: requester 0 is served first, then requester 1, with ack1 three cycles after ack0. Both held high for 6 ops: grant order 0,1,0,1,0,1 and each counter reads 3.
- Requester 0 changes a0 and drops req0 during EXEC. Required: the result reflects the originally latched operands and ack0 is still issued.
- Assert rst during EXEC. Required: no ack; result=0, zero=0, busy=0, counters=0 on the next cycle; the next tie goes to requester 0.
- With CNT_W=2, issue 5 requester-0 ops. Required: gnt_cnt0 saturates at 3.
